// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit that owns the architectural HI/LO pair.
// Define MD_DIV_EN to build the restoring divider; without it DIV/DIVU decode as no-ops.
module md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StartE,
  input  logic [2:0]       MDOpE,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  output logic             BusyMD,
  output logic             DoneMD,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int         CW      = $clog2(WIDTH);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  state_t r_state, w_state_nx;

  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic               r_neg_res;

  logic               w_idle, w_mul_op, w_div_op, w_signed, w_start, w_mt;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_fix_res;

  assign w_idle   = (r_state == S_IDLE);
  assign w_mul_op = (MDOpE[2:1] == 2'b00);
`ifdef MD_DIV_EN
  assign w_div_op = (MDOpE[2:1] == 2'b01);
`else
  assign w_div_op = 1'b0;
`endif
  assign w_signed = ~MDOpE[0];
  assign w_start  = StartE & w_idle & (w_mul_op | w_div_op);
  assign w_mt     = StartE & w_idle & ((MDOpE == OP_MTHI) | (MDOpE == OP_MTLO));

  // Magnitudes are unsigned, so -2^31 survives negation as 0x80000000.
  assign w_abs_a = (w_signed && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
  assign w_abs_b = (w_signed && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;

  assign BusyMD = (r_state != S_IDLE);

  // Shift-add: r_opa is the multiplicand, r_opb shifts the multiplier out LSB first.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opa};
  assign w_mul_next = r_opb[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

`ifdef MD_DIV_EN
  logic               r_is_div, r_neg_rem;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_div_next;

  // Restoring step: upper half is the partial remainder, lower half collects quotient bits.
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_opa[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_opb};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_div_next = {(w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_qbit};
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    w_fix_res = r_neg_res ? -r_acc : r_acc;
`ifdef MD_DIV_EN
    if (r_is_div) begin
      w_fix_res[2*WIDTH-1:WIDTH] = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      w_fix_res[WIDTH-1:0]       = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    end
`endif
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nx = S_RUN;
      S_RUN:   if (r_cnt == CW'(WIDTH-1)) w_state_nx = S_FIX;
      S_FIX:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_neg_res <= 1'b0;
`ifdef MD_DIV_EN
      r_is_div  <= 1'b0;
      r_neg_rem <= 1'b0;
`endif
      HI        <= '0;
      LO        <= '0;
      DoneMD    <= 1'b0;
    end else begin
      DoneMD <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_opa     <= w_abs_a;
            r_opb     <= w_abs_b;
            r_neg_res <= w_signed & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            r_acc     <= '0;
            r_cnt     <= '0;
`ifdef MD_DIV_EN
            r_is_div  <= w_div_op;
            r_neg_rem <= w_signed & SrcAE[WIDTH-1];
`endif
          end else if (w_mt) begin
            if (MDOpE == OP_MTHI) HI <= SrcAE;
            else                  LO <= SrcAE;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + CW'(1);
`ifdef MD_DIV_EN
          if (r_is_div) begin
            r_acc <= w_div_next;
            r_opa <= r_opa << 1;
          end else
`endif
          begin
            r_acc <= w_mul_next;
            r_opb <= r_opb >> 1;
          end
        end
        S_FIX:   {HI, LO} <= w_fix_res;
        default: ;
      endcase
    end
  end
endmodule
